// File: rtl/neuron_acc_if.sv
// neuron_acc_if: streaming handshake bundle between the bus-facing logic
// (master) and the neuron_acc MAC stage (slave).
//   start/n_inputs/bias      : kick off one neuron evaluation
//   in_valid/in_ready/x_in/w : Q16.16 activation/weight pair stream
//   busy                     : stage is not idle
//   out_valid/out_ready/x_float : IEEE-754 single pre-activation result
interface neuron_acc_if #(
  parameter int N_MAX = 16
);
  localparam int CW = $clog2(N_MAX + 1);

  logic          start;
  logic [CW-1:0] n_inputs;
  logic [31:0]   bias;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   x_in;
  logic [31:0]   w_in;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   x_float;

  modport master (
    output start, n_inputs, bias, in_valid, x_in, w_in, out_ready,
    input  in_ready, busy, out_valid, x_float
  );

  modport slave (
    input  start, n_inputs, bias, in_valid, x_in, w_in, out_ready,
    output in_ready, busy, out_valid, x_float
  );
endinterface

// File: rtl/neuron_acc.sv
// neuron_acc: sequential multiply-accumulate stage feeding the sigmoid unit.
// Accumulates bias + sum(x_in*w_in) exactly in a 72-bit Q40.32 register,
// then converts to IEEE-754 single (round to nearest, ties to even).
//   CLOCK_50 : clock, rising edge
//   Reset    : synchronous, active-high
//   bus      : neuron_acc_if.slave (start/n_inputs/bias, input pair stream,
//              busy, result stream x_float)
// Optional build macro NEURON_ACC_CLAMP_EN: saturates |acc| to 16.0 ahead of
// the float conversion; latency is unchanged.
module neuron_acc #(
  parameter int N_MAX = 16
) (
  input  logic         CLOCK_50,
  input  logic         Reset,
  neuron_acc_if.slave  bus
);
  localparam int CW = $clog2(N_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_ACC, S_CONV1, S_CONV2, S_OUT} state_t;

  state_t        state_q, state_d;
  logic [71:0]   acc_q, acc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] n_q, n_d;
  logic          sign_q, sign_d;
  logic [71:0]   mag_q, mag_d;
  logic [6:0]    lead_q, lead_d;
  logic [31:0]   x_float_q, x_float_d;

  logic signed [63:0] prod;
  logic               last_pair;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      count_q   <= '0;
      n_q       <= '0;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      lead_q    <= '0;
      x_float_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      n_q       <= n_d;
      sign_q    <= sign_d;
      mag_q     <= mag_d;
      lead_q    <= lead_d;
      x_float_q <= x_float_d;
    end
  end

  assign prod      = $signed(bus.x_in) * $signed(bus.w_in);
  assign last_pair = (count_q + CW'(1)) == n_q;

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.n_inputs == '0) state_d = S_CONV1;
          else                    state_d = S_ACC;
        end
      end
      S_ACC:   if (bus.in_valid && last_pair) state_d = S_CONV1;
      S_CONV1: state_d = S_CONV2;
      S_CONV2: state_d = S_OUT;
      S_OUT:   if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ----------------------------------------------------------------- datapath
  logic [71:0] abs_c;
  logic [71:0] mag_c;
  logic [6:0]  lead_c;
  logic [71:0] norm;
  logic [24:0] mant_r;
  logic        round_up;
  logic [7:0]  exp_c;

  always_comb begin
    abs_c = acc_q[71] ? (~acc_q + 72'd1) : acc_q;
`ifdef NEURON_ACC_CLAMP_EN
    // 16.0 in Q40.32; the spu is already saturated beyond this
    mag_c = (abs_c > (72'd1 << 36)) ? (72'd1 << 36) : abs_c;
`else
    mag_c = abs_c;
`endif
    // Priority encoder: ascending scan, so the highest set bit wins
    lead_c = '0;
    for (int i = 0; i < 72; i++) begin
      if (mag_c[i]) lead_c = 7'(i);
    end
  end

  always_comb begin
    // Left-justify so the leading one sits at bit 71; keep 24 bits,
    // bit 47 is guard, everything below is sticky.
    norm     = mag_q << (7'd71 - lead_q);
    round_up = norm[47] & ((|norm[46:0]) | norm[48]);
    mant_r   = {1'b0, norm[71:48]} + {24'd0, round_up};
    // Q.32 scaling: bit 32 is 2^0, so biased exponent = lead + 95
    exp_c    = 8'({1'b0, lead_q}) + 8'd95 + {7'd0, mant_r[24]};
  end

  always_comb begin
    acc_d     = acc_q;
    count_d   = count_q;
    n_d       = n_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    lead_d    = lead_q;
    x_float_d = x_float_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          acc_d   = {{24{bus.bias[31]}}, bus.bias, 16'h0};
          count_d = '0;
          n_d     = (int'(bus.n_inputs) > N_MAX) ? CW'(N_MAX) : bus.n_inputs;
        end
      end
      S_ACC: begin
        if (bus.in_valid) begin
          acc_d   = acc_q + {{8{prod[63]}}, prod};
          count_d = count_q + CW'(1);
        end
      end
      S_CONV1: begin
        sign_d = acc_q[71];
        mag_d  = mag_c;
        lead_d = lead_c;
      end
      S_CONV2: begin
        if (mag_q == '0) x_float_d = 32'h0000_0000;
        else x_float_d = {sign_q, exp_c,
                          mant_r[24] ? mant_r[23:1] : mant_r[22:0]};
      end
      default: ;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    bus.in_ready  = (state_q == S_ACC);
    bus.out_valid = (state_q == S_OUT);
    bus.busy      = (state_q != S_IDLE);
    bus.x_float   = x_float_q;
  end
endmodule

// File: tb/tb_neuron_acc.sv
module tb_neuron_acc;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  neuron_acc_if #(.N_MAX(16)) bus ();
  neuron_acc #(.N_MAX(16)) dut (.CLOCK_50(clk), .Reset(rst), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic begin_run(input logic [4:0] n, input logic [31:0] b);
    bus.n_inputs = n; bus.bias = b; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] w);
    int t;
    bus.x_in = x; bus.w_in = w; bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 20) begin step(); t++; end
    if (t >= 20) chk("in_ready_timeout", 32'd0, 32'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  // lat counts cycles from the triggering edge until out_valid is seen
  task automatic wait_out(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 30) begin step(); lat++; end
    chk("out_valid_seen", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic take(input string tag, input logic [31:0] exp_v);
    chk(tag, bus.x_float, exp_v);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, "_ov_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  int lat;
  logic [31:0] held;
  logic [31:0] round_exp;

  initial begin
    rst = 1'b1;
    bus.start = 0; bus.n_inputs = '0; bus.bias = '0;
    bus.in_valid = 0; bus.x_in = '0; bus.w_in = '0; bus.out_ready = 0;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_x_float",   bus.x_float,        32'h0);

    // 1.0*2.0 + 0.5*(-1.0) = 1.5, with backpressure in OUT
    begin_run(5'd2, 32'h0);
    send(32'h0001_0000, 32'h0002_0000);
    send(32'h0000_8000, 32'hFFFF_0000);
    wait_out(lat);
    chk("lat_n2", 32'(lat), 32'd3);
    chk("val_1p5", bus.x_float, 32'h3FC0_0000);
    held = bus.x_float;
    for (int i = 0; i < 5; i++) begin
      bus.start = (i == 2); bus.n_inputs = '0;
      step();
      bus.start = 1'b0;
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_x_float",   bus.x_float,        held);
      chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
      chk("bp_busy",      32'(bus.busy),      32'd1);
    end
    take("bp_release", 32'h3FC0_0000);
    chk("bp_idle", 32'(bus.busy), 32'd0);

    // n=0: bias only, -1.0
    begin_run(5'd0, 32'hFFFF_0000);
    wait_out(lat);
    chk("lat_n0", 32'(lat), 32'd3);
    take("val_m1", 32'hBF80_0000);

    // zero product must be +0
    begin_run(5'd1, 32'h0);
    send(32'h0, 32'h1234_5678);
    wait_out(lat);
    take("val_pos_zero", 32'h0000_0000);

    // round-up carries into the exponent
`ifdef NEURON_ACC_CLAMP_EN
    round_exp = 32'h4180_0000;
`else
    round_exp = 32'h4700_0000;
`endif
    begin_run(5'd1, 32'h0);
    send(32'h7FFF_FFFF, 32'h0001_0000);
    wait_out(lat);
    take("val_round", round_exp);

    // gapped in_valid: 1.0*1.0 + 2.0*2.0 + 0.25*4.0 = 6.0
    begin_run(5'd3, 32'h0);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = ~i[0];
      case (i)
        0: begin bus.x_in = 32'h0001_0000; bus.w_in = 32'h0001_0000; end
        2: begin bus.x_in = 32'h0002_0000; bus.w_in = 32'h0002_0000; end
        4: begin bus.x_in = 32'h0000_4000; bus.w_in = 32'h0004_0000; end
        default: begin bus.x_in = 32'h7777_0000; bus.w_in = 32'h7777_0000; end
      endcase
      step();
    end
    bus.in_valid = 1'b0;
    chk("gap_in_ready_drop", 32'(bus.in_ready), 32'd0);
    wait_out(lat);
    chk("lat_gap", 32'(lat), 32'd3);
    take("val_gap", 32'h40C0_0000);

    // n_inputs above N_MAX is capped at 16: 16 * (1.0*1.0) = 16.0
    begin_run(5'd31, 32'h0);
    for (int i = 0; i < 16; i++) send(32'h0001_0000, 32'h0001_0000);
    chk("cap_in_ready_drop", 32'(bus.in_ready), 32'd0);
    wait_out(lat);
    take("val_cap16", 32'h4180_0000);

    // reset mid-operation aborts with no output
    begin_run(5'd2, 32'h0);
    send(32'h0001_0000, 32'h0001_0000);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("mid_rst_busy",      32'(bus.busy),      32'd0);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_x_float",   bus.x_float,        32'h0);
    for (int i = 0; i < 4; i++) step();
    chk("mid_rst_no_out", 32'(bus.out_valid), 32'd0);

    begin_run(5'd1, 32'h0);
    send(32'h0001_0000, 32'h0001_0000);
    wait_out(lat);
    take("val_after_rst", 32'h3F80_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
